// File: rtl/hwpe_ctrl_jobq_pkg.sv
// Shared constants and types for the HWPE job-queue controller.
// Register offsets are word indices (add_i[7:2]).
package hwpe_ctrl_package;

    localparam logic [5:0] REG_TRIGGER   = 6'h00;
    localparam logic [5:0] REG_ACQUIRE   = 6'h01;
    localparam logic [5:0] REG_FINISHED  = 6'h02;
    localparam logic [5:0] REG_STATUS    = 6'h03;
    localparam logic [5:0] REG_RUNNING   = 6'h04;
    localparam logic [5:0] REG_SOFTCLEAR = 6'h05;

    localparam logic [31:0] ACQUIRE_FAIL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FSM_IDLE     = 2'd0,
        FSM_STARTING = 2'd1,
        FSM_RUNNING  = 2'd2
    } jobq_state_e;

endpackage

// File: rtl/hwpe_ctrl_jobq_fifo.sv
// Circular buffer of job owner indices; the write pointer doubles as the
// context slot handed out by ACQUIRE, the read pointer as the running slot.
module hwpe_ctrl_jobq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 3,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [PW-1:0] wptr_o,
    output logic [PW-1:0] rptr_o,
    output logic [NW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [PW-1:0]            wptr_q, rptr_q;
    logic [NW-1:0]            count_q, count_d;
    logic                     push_ok, pop_ok;

    assign full_o  = (count_q == NW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];
    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
                wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            end
            if (pop_ok) begin
                rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_jobq.sv
// HWPE job-queue controller: lock/acquire/trigger offload protocol and engine FSM.
// Define HWPE_CTRL_JOBQ_WATCHDOG_EN to add the RUNNING-state timeout watchdog.
module hwpe_ctrl_jobq
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned  N_CORES        = 8,
    parameter int unsigned  N_CONTEXT      = 4,
    parameter int unsigned  N_EVT          = 2,
    parameter int unsigned  CLEAR_CYCLES   = 3,
    parameter logic [31:0]  TIMEOUT_CYCLES = 32'd65535,
    localparam int unsigned CW  = $clog2(N_CONTEXT),
    localparam int unsigned IW  = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int unsigned NW  = $clog2(N_CONTEXT + 1),
    localparam int unsigned CLW = $clog2(CLEAR_CYCLES + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_i,
    output logic                            gnt_o,
    input  logic [7:0]                      add_i,
    input  logic                            wen_i,
    input  logic [31:0]                     data_i,
    input  logic [N_CORES-1:0]              id_i,
    output logic [31:0]                     r_data_o,
    output logic                            r_valid_o,
    output logic [N_CORES-1:0]              r_id_o,
    output logic                            start_o,
    output logic [CW-1:0]                   ctx_o,
    input  logic                            done_i,
    output logic                            busy_o,
    output logic                            full_o,
    output logic [N_CORES-1:0][N_EVT-1:0]   evt_o,
    output logic                            clear_o
);

    jobq_state_e                     state_q;
    logic                            start_q, busy_q;
    logic [N_CORES-1:0][N_EVT-1:0]   evt_q;
    logic [31:0]                     finished_q;
    logic                            lock_q;
    logic [N_CORES-1:0]              owner_q;
    logic [CLW-1:0]                  clear_cnt_q;
    logic                            r_valid_q;
    logic [N_CORES-1:0]              r_id_q;
    logic [31:0]                     r_data_q, r_data_d;

    logic [5:0]    reg_sel;
    logic          clear_act, rd_req, wr_req;
    logic          acq_ok, trig_ok, sclr_ok;
    logic [IW-1:0] id_idx, fifo_head;
    logic [CW-1:0] fifo_wptr, fifo_rptr;
    logic [NW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          job_end, pop;
    logic          wd_expired, wd_err;
    logic          unused_bits;

    assign unused_bits = ^{data_i, add_i[1:0]};

    assign reg_sel   = add_i[7:2];
    assign clear_act = (clear_cnt_q != '0);
    assign rd_req    = req_i && wen_i;
    assign wr_req    = req_i && !wen_i;

    assign acq_ok  = rd_req && !clear_act && (reg_sel == REG_ACQUIRE)
                     && !fifo_full && !lock_q;
    assign trig_ok = wr_req && !clear_act && (reg_sel == REG_TRIGGER)
                     && lock_q && (id_i == owner_q);
    assign sclr_ok = wr_req && !clear_act && (reg_sel == REG_SOFTCLEAR);

    // Lowest set bit wins if a malformed multi-hot id arrives.
    always_comb begin
        id_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (id_i[i]) id_idx = IW'(i);
        end
    end

    assign job_end = (state_q == FSM_RUNNING) && (done_i || wd_expired);
    assign pop     = job_end && !clear_act;

    hwpe_ctrl_jobq_fifo #(
        .DEPTH (N_CONTEXT),
        .DW    (IW)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_act),
        .push_i  (trig_ok),
        .data_i  (id_idx),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .wptr_o  (fifo_wptr),
        .rptr_o  (fifo_rptr),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef HWPE_CTRL_JOBQ_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
    logic        wd_err_q;

    // Counts cycles since start_o; cleared whenever the engine is idle.
    assign wd_expired = (state_q == FSM_RUNNING)
                        && (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
    assign wd_err     = wd_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else if (clear_act) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (state_q == FSM_IDLE || job_end) wd_cnt_q <= '0;
            else                                wd_cnt_q <= wd_cnt_q + 32'd1;
            if (wd_expired && !done_i) wd_err_q <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign wd_err     = 1'b0;
`endif

    always_comb begin
        r_data_d = '0;
        if (rd_req && !clear_act) begin
            case (reg_sel)
                REG_ACQUIRE:  r_data_d = acq_ok ? 32'(fifo_wptr) : ACQUIRE_FAIL;
                REG_FINISHED: r_data_d = finished_q;
                REG_STATUS:   r_data_d = {27'd0, wd_err, lock_q, fifo_full,
                                          busy_q, fifo_cnt != '0};
                REG_RUNNING:  r_data_d = 32'({busy_q, fifo_rptr});
                default:      r_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= req_i;
            r_id_q    <= req_i ? id_i : '0;
            r_data_q  <= r_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clear_cnt_q <= '0;
        end else if (sclr_ok) begin
            clear_cnt_q <= CLW'(CLEAR_CYCLES);
        end else if (clear_act) begin
            clear_cnt_q <= clear_cnt_q - CLW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (clear_act) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (acq_ok) begin
            lock_q  <= 1'b1;
            owner_q <= id_i;
        end else if (trig_ok) begin
            lock_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FSM_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            evt_q      <= '0;
            finished_q <= '0;
        end else if (clear_act) begin
            state_q    <= FSM_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            evt_q      <= '0;
            finished_q <= '0;
        end else begin
            start_q <= 1'b0;
            evt_q   <= '0;
            case (state_q)
                FSM_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= FSM_STARTING;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FSM_STARTING: state_q <= FSM_RUNNING;
                FSM_RUNNING: begin
                    if (job_end) begin
                        state_q    <= FSM_IDLE;
                        busy_q     <= 1'b0;
                        finished_q <= finished_q + 32'd1;
                        evt_q[fifo_head][0] <= done_i;
                        evt_q[fifo_head][1] <= wd_expired && !done_i;
                    end
                end
                default: state_q <= FSM_IDLE;
            endcase
        end
    end

    assign gnt_o     = 1'b1;
    assign r_data_o  = r_data_q;
    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;
    assign start_o   = start_q;
    assign busy_o    = busy_q;
    assign ctx_o     = fifo_rptr;
    assign full_o    = fifo_full;
    assign evt_o     = evt_q;
    assign clear_o   = clear_act;

endmodule

// File: tb/tb_hwpe_ctrl_jobq.sv
// Scoreboard bench for hwpe_ctrl_jobq: read responses are queued at issue
// and checked when r_valid_o fires; control outputs are checked in-line.
module tb_hwpe_ctrl_jobq;

    localparam int NC = 8;
    localparam int NE = 2;

    localparam logic [7:0] A_TRIG = 8'h00;
    localparam logic [7:0] A_ACQ  = 8'h04;
    localparam logic [7:0] A_FIN  = 8'h08;
    localparam logic [7:0] A_STAT = 8'h0C;
    localparam logic [7:0] A_RUN  = 8'h10;
    localparam logic [7:0] A_SCLR = 8'h14;
    localparam logic [31:0] FAIL_V = 32'hFFFF_FFFF;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   req_i;
    logic                   gnt_o;
    logic [7:0]             add_i;
    logic                   wen_i;
    logic [31:0]            data_i;
    logic [NC-1:0]          id_i;
    logic [31:0]            r_data_o;
    logic                   r_valid_o;
    logic [NC-1:0]          r_id_o;
    logic                   start_o;
    logic [1:0]             ctx_o;
    logic                   done_i;
    logic                   busy_o;
    logic                   full_o;
    logic [NC-1:0][NE-1:0]  evt_o;
    logic                   clear_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   exp_q[$];
    logic [NC-1:0] eid_q[$];
    string         tag_q[$];

    hwpe_ctrl_jobq #(
        .N_CORES        (NC),
        .N_CONTEXT      (4),
        .N_EVT          (NE),
        .CLEAR_CYCLES   (3),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .data_i    (data_i),
        .id_i      (id_i),
        .r_data_o  (r_data_o),
        .r_valid_o (r_valid_o),
        .r_id_o    (r_id_o),
        .start_o   (start_o),
        .ctx_o     (ctx_o),
        .done_i    (done_i),
        .busy_o    (busy_o),
        .full_o    (full_o),
        .evt_o     (evt_o),
        .clear_o   (clear_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input logic [7:0] a, input logic rd,
                       input int core, input logic [31:0] exp,
                       input string tag);
        req_i  = 1'b1;
        add_i  = a;
        wen_i  = rd;
        data_i = 32'hA5A5_0000 | 32'(core);
        id_i   = NC'(1) << core;
        exp_q.push_back(exp);
        eid_q.push_back(NC'(1) << core);
        tag_q.push_back(tag);
        tick();
        req_i  = 1'b0;
        add_i  = '0;
        wen_i  = 1'b0;
        data_i = '0;
        id_i   = '0;
    endtask

    task automatic wait_running();
        int n = 0;
        while (!(busy_o && !start_o)) begin
            if (n == 30) begin
                chk("run_timeout", 32'd0, 32'd1);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic run_done();
        wait_running();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && r_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                automatic logic [31:0]   e   = exp_q.pop_front();
                automatic logic [NC-1:0] eid = eid_q.pop_front();
                automatic string         t   = tag_q.pop_front();
                chk(t, r_data_o, e);
                chk({t, "_rid"}, 32'(r_id_o), 32'(eid));
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        req_i  = 1'b0;
        add_i  = '0;
        wen_i  = 1'b0;
        data_i = '0;
        id_i   = '0;
        done_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd1);
        chk("rst_rvalid", 32'(r_valid_o), 32'd0);
        chk("rst_rdata", r_data_o, 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_evt", 32'(evt_o), 32'd0);
        chk("rst_clear", 32'(clear_o), 32'd0);
        chk("rst_ctx", 32'(ctx_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Single job from core 2
        cfg(A_ACQ, 1'b1, 2, 32'd0, "acq_c2");
        cfg(A_TRIG, 1'b0, 2, 32'd0, "trig_c2");
        chk("start_early", 32'(start_o), 32'd0);
        tick();
        chk("start_pulse", 32'(start_o), 32'd1);
        chk("busy_starting", 32'(busy_o), 32'd1);
        chk("ctx_first", 32'(ctx_o), 32'd0);
        tick();
        chk("start_one_cycle", 32'(start_o), 32'd0);
        chk("busy_running", 32'(busy_o), 32'd1);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("evt_c2", 32'(evt_o), 32'h10);
        chk("busy_after_done", 32'(busy_o), 32'd0);
        tick();
        chk("evt_c2_cleared", 32'(evt_o), 32'd0);
        cfg(A_FIN, 1'b1, 2, 32'd1, "finished_1");
        cfg(A_STAT, 1'b1, 2, 32'd0, "status_idle");
        cfg(A_RUN, 1'b1, 2, 32'd1, "running_idle");

        // Fill the queue with the engine stalled
        begin
            int cores[4] = '{5, 6, 7, 0};
            for (int i = 0; i < 4; i++) begin
                cfg(A_ACQ, 1'b1, cores[i], 32'((1 + i) % 4), "acq_fill");
                cfg(A_TRIG, 1'b0, cores[i], 32'd0, "trig_fill");
            end
        end
        chk("full_4", 32'(full_o), 32'd1);
        cfg(A_ACQ, 1'b1, 1, FAIL_V, "acq_when_full");
        cfg(A_STAT, 1'b1, 1, 32'd7, "status_full");
        cfg(A_RUN, 1'b1, 1, 32'd5, "running_busy");
        run_done();
        chk("evt_c5", 32'(evt_o), 32'h400);
        run_done();
        chk("evt_c6", 32'(evt_o), 32'h1000);

        // Push and pop in the same cycle at count 2
        cfg(A_ACQ, 1'b1, 1, 32'd1, "acq_c1_cnt2");
        wait_running();
        done_i = 1'b1;
        cfg(A_TRIG, 1'b0, 1, 32'd0, "trig_with_done");
        done_i = 1'b0;
        chk("evt_c7", 32'(evt_o), 32'h4000);
        chk("full_cnt2", 32'(full_o), 32'd0);
        cfg(A_ACQ, 1'b1, 3, 32'd2, "acq_c3_cnt2");
        cfg(A_TRIG, 1'b0, 3, 32'd0, "trig_c3_cnt2");
        chk("full_cnt3", 32'(full_o), 32'd0);
        cfg(A_ACQ, 1'b1, 4, 32'd3, "acq_c4_cnt3");
        cfg(A_TRIG, 1'b0, 4, 32'd0, "trig_c4_cnt3");
        chk("full_after_same_cycle", 32'(full_o), 32'd1);

        // Soft clear while the engine is running
        wait_running();
        cfg(A_SCLR, 1'b0, 0, 32'd0, "softclear");
        chk("clear_c1", 32'(clear_o), 32'd1);
        cfg(A_FIN, 1'b1, 0, 32'd0, "finished_during_clear");
        chk("clear_c2", 32'(clear_o), 32'd1);
        tick();
        chk("clear_c3", 32'(clear_o), 32'd1);
        tick();
        chk("clear_off", 32'(clear_o), 32'd0);
        chk("busy_cleared", 32'(busy_o), 32'd0);
        chk("full_cleared", 32'(full_o), 32'd0);
        cfg(A_STAT, 1'b1, 0, 32'd0, "status_cleared");
        cfg(A_FIN, 1'b1, 0, 32'd0, "finished_cleared");

        // Lock held by core 1; core 3 is locked out
        cfg(A_ACQ, 1'b1, 1, 32'd0, "acq_c1_lock");
        cfg(A_ACQ, 1'b1, 3, FAIL_V, "acq_c3_locked");
        cfg(A_TRIG, 1'b0, 3, 32'd0, "trig_c3_foreign");
        tick();
        tick();
        chk("no_start_foreign", 32'(busy_o), 32'd0);
        cfg(A_STAT, 1'b1, 3, 32'd8, "status_lock_only");
        cfg(A_TRIG, 1'b0, 1, 32'd0, "trig_c1_owner");
        run_done();
        chk("evt_c1", 32'(evt_o), 32'h4);
        cfg(A_FIN, 1'b1, 1, 32'd1, "finished_after_clear");

        cfg(8'h1C, 1'b0, 2, 32'd0, "unmapped_wr");
        cfg(8'h1C, 1'b1, 2, 32'd0, "unmapped_rd");

`ifdef HWPE_CTRL_JOBQ_WATCHDOG_EN
        cfg(A_ACQ, 1'b1, 6, 32'd1, "acq_c6_wd");
        cfg(A_TRIG, 1'b0, 6, 32'd0, "trig_c6_wd");
        begin
            int n = 0;
            int k = 0;
            while (!start_o && n < 20) begin
                tick();
                n++;
            end
            chk("wd_start_seen", 32'(start_o), 32'd1);
            for (k = 1; k <= 40; k++) begin
                tick();
                if (evt_o != '0) break;
            end
            chk("wd_delay", 32'(k), 32'd16);
            chk("wd_evt_c6", 32'(evt_o), 32'h2000);
        end
        cfg(A_STAT, 1'b1, 6, 32'd16, "status_wd_error");
`endif

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_jobq.md
HWPE_CTRL_JOBQ -- requirements
Module: hwpe_ctrl_jobq

Interface
REQ-001 SHALL have parameter N_CORES, default 8: number of offloading cores, width of id_i/evt_o.
REQ-002 SHALL have parameter N_CONTEXT, default 4 (>=2): job queue depth; CW=$clog2(N_CONTEXT).
REQ-003 SHALL have parameter N_EVT, default 2: event lines per core.
REQ-004 SHALL have parameter CLEAR_CYCLES, default 3: soft-clear pulse length.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit, 32-bit.
REQ-006 SHALL have ports:
- clk_i in 1: clock.
- rst_ni in 1: reset, asynchronous, active-low.
- req_i in 1: config request.
- gnt_o out 1: grant, tied 1.
- add_i in 8: byte address; bits [7:2] select the register.
- wen_i in 1: 1=read, 0=write.
- data_i in 32: write data.
- id_i in N_CORES: one-hot requester.
- r_data_o out 32: read data.
- r_valid_o out 1: response valid.
- r_id_o out N_CORES: response id.
- start_o out 1: job start pulse.
- ctx_o out CW: running slot.
- done_i in 1: engine done.
- busy_o out 1: job active.
- full_o out 1: queue full.
- evt_o out N_CORES x N_EVT: events.
- clear_o out 1: soft clear.

Function
REQ-007 SHALL decode registers: 0x00 TRIGGER (W), 0x04 ACQUIRE (R), 0x08 FINISHED (R), 0x0C STATUS (R), 0x10 RUNNING (R), 0x14 SOFTCLEAR (W); other offsets read 0 and ignore writes.
REQ-008 SHALL assert r_valid_o, r_id_o=id_i and r_data_o exactly one cycle after every accepted req_i; writes return 0.
REQ-009 SHALL, on an ACQUIRE read with queue not full and no lock held, return the write pointer, set lock and record the owner id.
REQ-010 SHALL return 0xFFFFFFFF for an ACQUIRE read when full_o=1 or the lock is held.
REQ-011 SHALL, on a TRIGGER write from the lock owner, push the owner's core index, advance the write pointer modulo N_CONTEXT and release the lock; a TRIGGER from a non-owner or with no lock SHALL be ignored.
REQ-012 SHALL hold pending count 0..N_CONTEXT; full_o=(count==N_CONTEXT); a push and pop in the same cycle leave count unchanged.
REQ-013 SHALL run FSM IDLE->STARTING when count>0, STARTING->RUNNING with start_o=1 for that one cycle, RUNNING->IDLE on done_i (pop, read pointer+1).
REQ-014 SHALL drive busy_o=1 in STARTING and RUNNING, and ctx_o = read pointer.
REQ-015 SHALL ignore done_i outside RUNNING.
REQ-016 SHALL pulse evt_o[owner][0] for one cycle, one cycle after the accepted done_i; owner is the popped core index; all other bits 0.
REQ-017 SHALL increment FINISHED (32-bit, wraps) per completed job.
REQ-018 SHALL read STATUS as {27'b0, error, lock, full_o, busy_o, count!=0}.
REQ-019 SHALL read RUNNING as {busy_o, ctx_o} zero-extended.
REQ-020 SHALL, on a SOFTCLEAR write, assert clear_o from the next cycle for CLEAR_CYCLES cycles; SOFTCLEAR writes during clear are ignored.
REQ-021 SHALL, while clear_o=1, reset pointers, count, lock, FSM, FINISHED and error; requests still respond with r_data_o=0.

Reset
REQ-022 SHALL on rst_ni=0 drive all outputs 0 except gnt_o=1, FSM=IDLE, and zero all counters, pointers and the lock.

Configuration
REQ-023 SHALL, with HWPE_CTRL_JOBQ_WATCHDOG_EN defined, count RUNNING cycles; at TIMEOUT_CYCLES without done_i:
- treat the job as done;
- pulse evt_o[owner][1];
- set sticky STATUS.error.
REQ-024 SHALL, without HWPE_CTRL_JOBQ_WATCHDOG_EN, instantiate no watchdog; STATUS.error reads 0 and evt_o[*][1] stays 0.

Structure
REQ-025 SHALL place register offset constants and the FSM state enum typedef in hwpe_ctrl_package.
REQ-026 SHALL implement the owner-index circular buffer as sub-module hwpe_ctrl_jobq_fifo (push, pop, count, full, empty).

Verification
REQ-027 SHALL test: core 2 ACQUIRE->0, TRIGGER -> start_o 2 cycles later, done_i -> evt_o[2][0] pulse, FINISHED=1.
REQ-028 SHALL test: 4 acquire/trigger pairs with the engine stalled -> full_o=1, 5th ACQUIRE=0xFFFFFFFF.
REQ-029 SHALL test: core 1 holds lock, core 3 ACQUIRE=0xFFFFFFFF and core 3 TRIGGER ignored (count unchanged).
REQ-030 SHALL test: TRIGGER and done_i in the same cycle at count=2 -> count stays 2.
REQ-031 SHALL test: SOFTCLEAR mid-RUNNING -> clear_o high 3 cycles, then STATUS=0 and FINISHED=0.
REQ-032 SHALL test, with WATCHDOG_EN and TIMEOUT_CYCLES=16: no done_i -> evt_o[owner][1] 16 cycles after start_o, STATUS bit4=1.
